// File: rtl/ctrl_pkg.sv
// Shared encodings and inter-stage bundles for the pipeline controller.
package ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;

  typedef struct packed {
    logic       regWrite;
    logic       memWrite;
    logic       memToReg;
    logic       branch;
    logic       pcs;
    logic [3:0] aluCtrl;
    logic       aluSrc;
    logic [1:0] flagW;
    logic [3:0] cond;
  } id_ex_t;

  typedef struct packed {
    logic regWrite;
    logic memWrite;
    logic pcSrc;
    logic memToReg;
  } ex_mem_t;

  typedef struct packed {
    logic regWrite;
    logic pcSrc;
    logic memToReg;
  } mem_wb_t;

endpackage

// File: rtl/cond_unit.sv
// E-stage condition evaluation and the architectural NZCV register.
module cond_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluFlags,
  input  logic [1:0] flagW,
  output logic       condEx,
  output logic [3:0] flags
);

  logic n, z, c, v;
  assign {n, z, c, v} = flags;

  always_comb begin
    condEx = 1'b0;
    case (cond)
      COND_EQ: condEx = z;
      COND_NE: condEx = ~z;
      COND_CS: condEx = c;
      COND_CC: condEx = ~c;
      COND_MI: condEx = n;
      COND_PL: condEx = ~n;
      COND_VS: condEx = v;
      COND_VC: condEx = ~v;
      COND_HI: condEx = c & ~z;
      COND_LS: condEx = ~c | z;
      COND_GE: condEx = (n == v);
      COND_LT: condEx = (n != v);
      COND_GT: condEx = ~z & (n == v);
      COND_LE: condEx = z | (n != v);
      COND_AL: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  // NZ and CV halves are written independently so logic ops keep C/V
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= '0;
    end else if (condEx) begin
      if (flagW[FLAGW_NZ]) flags[3:2] <= aluFlags[3:2];
      if (flagW[FLAGW_CV]) flags[1:0] <= aluFlags[1:0];
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined D/E/M/W controller; define BRANCH_MISPREDICT_EN
// to add the E-stage branch misprediction detector.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W  = 4,
  parameter int REG_ADDR_W = 4,
  parameter int PC_REG     = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            op_d,
  input  logic [5:0]            funct_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic [3:0]            cond_d,
  input  logic [3:0]            alu_flags_e,
  input  logic                  flush_e,
  input  logic                  pred_taken_d,
  output logic [1:0]            regsrc_d,
  output logic [1:0]            immsrc_d,
  output logic [ALUCTRL_W-1:0]  alucontrol_e,
  output logic                  alusrc_e,
  output logic                  memtoreg_e,
  output logic                  branch_taken_e,
  output logic                  pcsrc_m,
  output logic                  pcsrc_w,
  output logic                  regwrite_m,
  output logic                  regwrite_w,
  output logic                  memwrite_m,
  output logic                  memtoreg_w,
  output logic [3:0]            flags_q,
  output logic                  mispredict_e
);

  id_ex_t  decD, idEx;
  ex_mem_t exMem;
  mem_wb_t memWb;
  logic    condEx;
  logic    iBit, sBit;
  logic [3:0] cmd;

  assign iBit = funct_d[5];
  assign cmd  = funct_d[4:1];
  assign sBit = funct_d[0];

  always_comb begin
    decD      = '0;
    regsrc_d  = 2'b00;
    immsrc_d  = 2'b00;
    decD.cond = cond_d;
    unique case (1'b1)
      (op_d == OP_DP): begin
        decD.aluSrc  = iBit;
        decD.aluCtrl = cmd;
        unique case (1'b1)
          (cmd == CMD_ADD) || (cmd == CMD_SUB): begin
            decD.regWrite        = 1'b1;
            decD.flagW[FLAGW_NZ] = sBit;
            decD.flagW[FLAGW_CV] = sBit;
          end
          (cmd == CMD_AND) || (cmd == CMD_ORR) ||
          (cmd == CMD_MOV): begin
            decD.regWrite        = 1'b1;
            decD.flagW[FLAGW_NZ] = sBit;
          end
          (cmd == CMD_CMP): begin
            decD.aluCtrl = ALU_SUB;
            decD.flagW   = 2'b11;
          end
          default: ;
        endcase
      end
      (op_d == OP_MEM): begin
        decD.regWrite = sBit;
        decD.memToReg = sBit;
        decD.memWrite = ~sBit;
        decD.aluSrc   = ~iBit;
        decD.aluCtrl  = funct_d[3] ? ALU_ADD : ALU_SUB;
        immsrc_d      = 2'b01;
        regsrc_d      = 2'b10;
      end
      (op_d == OP_BR): begin
        decD.branch   = 1'b1;
        decD.regWrite = funct_d[4];
        decD.aluSrc   = 1'b1;
        decD.aluCtrl  = ALU_ADD;
        immsrc_d      = 2'b10;
        regsrc_d      = 2'b01;
      end
      default: ;
    endcase
    decD.pcs = decD.regWrite &
      (rd_d == REG_ADDR_W'(PC_REG));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       idEx <= '0;
    else if (flush_e) idEx <= '0;
    else              idEx <= decD;
  end

  cond_unit uCond (
    .clk      (clk),
    .reset    (reset),
    .cond     (idEx.cond),
    .aluFlags (alu_flags_e),
    .flagW    (idEx.flagW),
    .condEx   (condEx),
    .flags    (flags_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exMem <= '0;
      memWb <= '0;
    end else begin
      exMem <= '{regWrite: idEx.regWrite & condEx,
                 memWrite: idEx.memWrite & condEx,
                 pcSrc:    idEx.pcs & condEx,
                 memToReg: idEx.memToReg};
      memWb <= '{regWrite: exMem.regWrite,
                 pcSrc:    exMem.pcSrc,
                 memToReg: exMem.memToReg};
    end
  end

  assign alucontrol_e   = ALUCTRL_W'(idEx.aluCtrl);
  assign alusrc_e       = idEx.aluSrc;
  assign memtoreg_e     = idEx.memToReg;
  assign branch_taken_e = idEx.branch & condEx;
  assign regwrite_m     = exMem.regWrite;
  assign memwrite_m     = exMem.memWrite;
  assign pcsrc_m        = exMem.pcSrc;
  assign regwrite_w     = memWb.regWrite;
  assign pcsrc_w        = memWb.pcSrc;
  assign memtoreg_w     = memWb.memToReg;

`ifdef BRANCH_MISPREDICT_EN
  logic predE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       predE <= 1'b0;
    else if (flush_e) predE <= 1'b0;
    else              predE <= pred_taken_d;
  end

  assign mispredict_e = idEx.branch & (condEx != predE);
`else
  logic unusedPred;
  assign unusedPred   = pred_taken_d;
  assign mispredict_e = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: directed scenarios
// followed by random instruction streams against a pipeline model.
module tb_pipe_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op_d;
  logic [5:0] funct_d;
  logic [3:0] rd_d;
  logic [3:0] cond_d;
  logic [3:0] alu_flags_e;
  logic       flush_e;
  logic       pred_taken_d;
  logic [1:0] regsrc_d, immsrc_d;
  logic [3:0] alucontrol_e;
  logic       alusrc_e, memtoreg_e, branch_taken_e;
  logic       pcsrc_m, pcsrc_w, regwrite_m, regwrite_w;
  logic       memwrite_m, memtoreg_w, mispredict_e;
  logic [3:0] flags_q;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(
    .ALUCTRL_W(4), .REG_ADDR_W(4), .PC_REG(15)
  ) dut (
    .clk(clk), .reset(reset), .op_d(op_d),
    .funct_d(funct_d), .rd_d(rd_d), .cond_d(cond_d),
    .alu_flags_e(alu_flags_e), .flush_e(flush_e),
    .pred_taken_d(pred_taken_d), .regsrc_d(regsrc_d),
    .immsrc_d(immsrc_d), .alucontrol_e(alucontrol_e),
    .alusrc_e(alusrc_e), .memtoreg_e(memtoreg_e),
    .branch_taken_e(branch_taken_e), .pcsrc_m(pcsrc_m),
    .pcsrc_w(pcsrc_w), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .memwrite_m(memwrite_m),
    .memtoreg_w(memtoreg_w), .flags_q(flags_q),
    .mispredict_e(mispredict_e)
  );

  typedef struct packed {
    logic [3:0] alu;
    logic asrc, mtrE, bt;
    logic rwM, mwM, pcM;
    logic rwW, pcW, mtrW;
    logic [3:0] flags;
    logic misp;
  } obs_t;

  typedef struct {
    bit rw, mw, mtr, br, pcs, asrc, pred;
    bit [3:0] alu;
    bit [1:0] fw;
    bit [3:0] cond;
  } ctl_t;

  int   tests = 0;
  int   fails = 0;
  obs_t sbq[$];

  ctl_t     eS;
  bit       mRw, mMw, mPc, mMtr;
  bit       wRw, wPc, wMtr;
  bit [3:0] fS;

  localparam bit [3:0] AL = 4'd14;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  function automatic bit holds(input bit [3:0] c,
                               input bit [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Control word described per instruction class
  function automatic ctl_t dec(input bit [1:0] op,
                               input bit [5:0] fn,
                               input bit [3:0] rd,
                               input bit [3:0] cond,
                               input bit pr);
    ctl_t c;
    bit [3:0] cmd;
    bit s;
    c = '{default: 0};
    c.cond = cond;
    c.pred = pr;
    cmd = fn[4:1];
    s = fn[0];
    if (op == 2'd0) begin
      c.asrc = fn[5];
      c.alu  = cmd;
      if (cmd == 4'd4 || cmd == 4'd2) begin
        c.rw = 1;
        c.fw = s ? 2'b11 : 2'b00;
      end else if (cmd == 4'd0 || cmd == 4'd12 ||
                   cmd == 4'd13) begin
        c.rw = 1;
        c.fw = s ? 2'b10 : 2'b00;
      end else if (cmd == 4'd10) begin
        c.alu = 4'd2;
        c.fw  = 2'b11;
      end
    end else if (op == 2'd1) begin
      c.rw   = s;
      c.mtr  = s;
      c.mw   = !s;
      c.asrc = !fn[5];
      c.alu  = fn[3] ? 4'd4 : 4'd2;
    end else if (op == 2'd2) begin
      c.br   = 1;
      c.rw   = fn[4];
      c.asrc = 1;
      c.alu  = 4'd4;
    end
    c.pcs = c.rw && (rd == 4'd15);
    return c;
  endfunction

  function automatic bit [1:0] expRegsrc(input bit [1:0] op);
    return (op == 2'd1) ? 2'b10 : (op == 2'd2) ? 2'b01 : 2'b00;
  endfunction

  function automatic bit [1:0] expImmsrc(input bit [1:0] op);
    return (op == 2'd1) ? 2'b01 : (op == 2'd2) ? 2'b10 : 2'b00;
  endfunction

  function automatic obs_t dutObs();
    obs_t a;
    a = '{alu: alucontrol_e, asrc: alusrc_e,
          mtrE: memtoreg_e, bt: branch_taken_e,
          rwM: regwrite_m, mwM: memwrite_m, pcM: pcsrc_m,
          rwW: regwrite_w, pcW: pcsrc_w, mtrW: memtoreg_w,
          flags: flags_q, misp: mispredict_e};
    return a;
  endfunction

  task automatic modelReset();
    eS = '{default: 0};
    {mRw, mMw, mPc, mMtr} = '0;
    {wRw, wPc, wMtr} = '0;
    fS = '0;
  endtask

  // Drive one D-stage instruction (af feeds the one now in E)
  task automatic issue(input bit [1:0] op, input bit [5:0] fn,
                       input bit [3:0] rd, input bit [3:0] cond,
                       input bit fl, input bit [3:0] af,
                       input bit pr);
    ctl_t d, ne;
    bit cx;
    bit [3:0] nf;
    obs_t e;
    @(negedge clk);
    op_d = op; funct_d = fn; rd_d = rd; cond_d = cond;
    flush_e = fl; alu_flags_e = af; pred_taken_d = pr;
    #1;
    check("regsrc", 32'(regsrc_d), 32'(expRegsrc(op)));
    check("immsrc", 32'(immsrc_d), 32'(expImmsrc(op)));
    d  = dec(op, fn, rd, cond, pr);
    cx = holds(eS.cond, fS);
    nf = fS;
    if (cx && eS.fw[1]) nf[3:2] = af[3:2];
    if (cx && eS.fw[0]) nf[1:0] = af[1:0];
    ne = d;
    if (fl) ne = '{default: 0};
    e.alu   = ne.alu;
    e.asrc  = ne.asrc;
    e.mtrE  = ne.mtr;
    e.bt    = ne.br && holds(ne.cond, nf);
    e.rwM   = eS.rw && cx;
    e.mwM   = eS.mw && cx;
    e.pcM   = eS.pcs && cx;
    e.rwW   = mRw;
    e.pcW   = mPc;
    e.mtrW  = mMtr;
    e.flags = nf;
`ifdef BRANCH_MISPREDICT_EN
    e.misp  = ne.br && (holds(ne.cond, nf) != ne.pred);
`else
    e.misp  = 1'b0;
`endif
    sbq.push_back(e);
    wRw = mRw; wPc = mPc; wMtr = mMtr;
    mRw = e.rwM; mMw = e.mwM; mPc = e.pcM; mMtr = eS.mtr;
    eS = ne;
    fS = nf;
    @(posedge clk);
  endtask

  task automatic driveNop();
    op_d = 2'b11; funct_d = '0; rd_d = '0; cond_d = '0;
    flush_e = 1'b0; alu_flags_e = '0; pred_taken_d = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle
  task automatic midReset();
    reset = 1'b0;
    #1;
    check("rst_memwrite_m", 32'(memwrite_m), 32'd0);
    check("rst_flags_q", 32'(flags_q), 32'd0);
    check("rst_all", 32'(dutObs()), 32'd0);
    sbq.delete();
    modelReset();
    driveNop();
    @(negedge clk);
    reset = 1'b1;
  endtask

  always begin : monitor
    obs_t exp;
    @(posedge clk);
    #1;
    if (reset && sbq.size() > 0) begin
      exp = sbq.pop_front();
      check("sb", 32'(dutObs()), 32'(exp));
    end
  end

  initial begin
    bit [1:0] op;
    bit [5:0] fn;
    bit [3:0] rd, cond;
    bit [3:0] cmds [6];
    cmds = '{4'd4, 4'd2, 4'd0, 4'd12, 4'd13, 4'd10};
    reset = 1'b0;
    driveNop();
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(dutObs()), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(2'd0, 6'b001001, 4'd1, AL, 0, 4'h0, 0);
    issue(2'd2, 6'b000000, 4'd0, 4'd0, 0, 4'b0100, 0);
    #2;
    check("adds_flags", 32'(flags_q), 32'h4);
    check("beq_taken", 32'(branch_taken_e), 32'd1);

    issue(2'd0, 6'b001001, 4'd1, AL, 0, 4'h0, 0);
    issue(2'd0, 6'b000001, 4'd2, AL, 0, 4'b0011, 0);
    #2;
    check("pre_ands_flags", 32'(flags_q), 32'h3);
    issue(2'd3, 6'b000000, 4'd0, AL, 0, 4'b1000, 0);
    #2;
    check("ands_keeps_cv", 32'(flags_q), 32'hB);

    issue(2'd0, 6'b010100, 4'd0, AL, 0, 4'h0, 0);
    issue(2'd0, 6'b001000, 4'd3, 4'd1, 0, 4'b0100, 0);
    issue(2'd3, 6'b000000, 4'd0, AL, 0, 4'hF, 0);
    #2;
    check("addne_no_write", 32'(regwrite_m), 32'd0);
    check("cmp_flags_kept", 32'(flags_q), 32'h4);

    issue(2'd0, 6'b011010, 4'd15, AL, 0, 4'h0, 0);
    issue(2'd3, 6'b000000, 4'd0, AL, 0, 4'h0, 0);
    #2;
    check("mov_pc_m", 32'(pcsrc_m), 32'd1);
    issue(2'd3, 6'b000000, 4'd0, AL, 0, 4'h0, 0);
    #2;
    check("mov_pc_w", 32'(pcsrc_w), 32'd1);

    issue(2'd0, 6'b001001, 4'd1, AL, 0, 4'h0, 0);
    issue(2'd3, 6'b000000, 4'd0, AL, 0, 4'b0000, 0);
    issue(2'd0, 6'b011010, 4'd15, 4'd0, 0, 4'h0, 0);
    issue(2'd3, 6'b000000, 4'd0, AL, 0, 4'h0, 0);
    #2;
    check("moveq_pc_m", 32'(pcsrc_m), 32'd0);
    issue(2'd3, 6'b000000, 4'd0, AL, 0, 4'h0, 0);
    #2;
    check("moveq_pc_w", 32'(pcsrc_w), 32'd0);

    issue(2'd2, 6'b010000, 4'd14, AL, 1, 4'h0, 1);
    #2;
    check("bl_flush_bt", 32'(branch_taken_e), 32'd0);
    check("bl_flush_alu", 32'(alucontrol_e), 32'd0);
    issue(2'd3, 6'b000000, 4'd0, AL, 0, 4'h0, 0);
    #2;
    check("bl_flush_rw_m", 32'(regwrite_m), 32'd0);

    issue(2'd2, 6'b000000, 4'd0, AL, 0, 4'h0, 0);
    #2;
`ifdef BRANCH_MISPREDICT_EN
    check("mispredict", 32'(mispredict_e), 32'd1);
`else
    check("mispredict", 32'(mispredict_e), 32'd0);
`endif

    issue(2'd0, 6'b001001, 4'd1, AL, 0, 4'h0, 0);
    issue(2'd1, 6'b001000, 4'd2, AL, 0, 4'hF, 0);
    issue(2'd3, 6'b000000, 4'd0, AL, 0, 4'h0, 0);
    #2;
    check("str_memwrite_m", 32'(memwrite_m), 32'd1);
    check("pre_rst_flags", 32'(flags_q), 32'hF);
    midReset();

    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      fn = 6'($urandom);
      if (op == 2'd0 && $urandom_range(0, 3) != 0)
        fn[4:1] = cmds[$urandom_range(0, 5)];
      rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
      cond = ($urandom_range(0, 2) == 0) ? AL : 4'($urandom);
      issue(op, fn, rd, cond,
            ($urandom_range(0, 7) == 0),
            4'($urandom), 1'($urandom));
      if (i == 200) begin
        #2;
        midReset();
      end
    end
    #3;
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
